// File: rtl/arith_defs_pkg.sv
// Shared definitions for the arithmetic lab datapath: sequencer state
// encodings and the default operand width used by the adder/subtractor blocks.
package arith_defs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ARITH_WIDTH = 4;

endpackage : arith_defs_pkg

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - br, with borrow out bo.
// Counterpart of the full_adder cell used by the adder datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ br;
    assign bo = (~a & b) | (~(a ^ b) & br);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Operands are captured on accept, then WIDTH clocks walk a single
// full-subtractor cell over the bits; the result is held in DONE until the
// consumer takes it. Borrow-out and signed overflow are reported with it.
module serial_subtractor
    import arith_defs_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q;
    logic               ovf_q;
    logic               fs_d;
    logic               fs_bo;
    logic               accept;
    logic               last_bit;

    // The cell always looks at the current LSB of the shifting operands.
    full_subtractor u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .br (br_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    assign accept   = in_valid && (state_q == IDLE);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept -> WIDTH shift edges -> hold until consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from state so reset shows at once.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand shift registers; contents are don't-care outside SHIFT.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state_q == SHIFT) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        end
    end

    // Bit counter, borrow chain and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            br_q   <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            br_q  <= bin;
        end else if (state_q == SHIFT) begin
            cnt_q <= cnt_q + 1'b1;
            br_q  <= fs_bo;
            // Result bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
            d_q   <= {fs_d, d_q[WIDTH-1:1]};
            if (last_bit) begin
                bout_q <= fs_bo;
                // Signed overflow: borrow into the MSB differs from borrow out.
                ovf_q  <= br_q ^ fs_bo;
            end
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations
// against an arithmetic reference model, with backpressure and async reset.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    // Reference-model bookkeeping for the cycle compare process.
    bit inflight = 1'b0;
    int acc_n    = 0;
    int ncyc     = 0;
    int op_a     = 0;
    int op_b     = 0;
    int op_bin   = 0;

    serial_subtractor #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int m_d(input int x, input int y, input int c);
        int t;
        t = x - y - c;
        return t & ((1 << W) - 1);
    endfunction

    function automatic int m_bout(input int x, input int y, input int c);
        return (x < y + c) ? 1 : 0;
    endfunction

    function automatic int m_ovf(input int x, input int y, input int c);
        int sx, sy, s;
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        s  = sx - sy - c;
        return (s < -(1 << (W - 1)) || s > (1 << (W - 1)) - 1) ? 1 : 0;
    endfunction

    // Cycle compare: handshake timing and result values against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_d", int'(d), 0);
            chk("rst_bout", int'(bout), 0);
            chk("rst_ovf", int'(ovf), 0);
            inflight = 1'b0;
        end else begin
            chk("cyc_in_ready", int'(in_ready), inflight ? 0 : 1);
            chk("cyc_out_valid", int'(out_valid),
                (inflight && ncyc >= acc_n + W + 1) ? 1 : 0);
            if (out_valid && inflight) begin
                chk("cyc_d", int'(d), m_d(op_a, op_b, op_bin));
                chk("cyc_bout", int'(bout), m_bout(op_a, op_b, op_bin));
                chk("cyc_ovf", int'(ovf), m_ovf(op_a, op_b, op_bin));
            end
            if (out_valid && out_ready && inflight)
                inflight = 1'b0;
            if (in_valid && in_ready) begin
                inflight = 1'b1;
                acc_n    = ncyc;
                op_a     = int'(a);
                op_b     = int'(b);
                op_bin   = int'(bin);
            end
        end
        ncyc++;
    end

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom_range(0, 1));
    endtask

    // One full operation; literal expectations are skipped when negative.
    task automatic do_op(input int xa, input int xb, input int xbin, input int hold,
                         input int ld, input int lbo, input int lov);
        int n;
        logic [W-1:0] dsave;
        logic bsave, osave;
        a        = W'(xa);
        b        = W'(xb);
        bin      = 1'(xbin);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 50) begin
            scramble_inputs();
            @(posedge clk); #1; n++;
        end
        chk("latency", n, W);
        if (!out_valid) begin
            in_valid = 1'b0;
            return;
        end
        if (ld >= 0)  chk("lit_d", int'(d), ld);
        if (lbo >= 0) chk("lit_bout", int'(bout), lbo);
        if (lov >= 0) chk("lit_ovf", int'(ovf), lov);
        dsave = d;
        bsave = bout;
        osave = ovf;
        repeat (hold) begin
            scramble_inputs();
            @(posedge clk); #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_d", int'(d), int'(dsave));
            chk("hold_bout", int'(bout), int'(bsave));
            chk("hold_ovf", int'(ovf), int'(osave));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_keep_d", int'(d), int'(dsave));
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("por_in_ready", int'(in_ready), 1);
        chk("por_out_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(7, 3, 0, 0, 4, 0, 0);
        do_op(3, 5, 0, 1, 14, 1, 0);
        do_op(8, 1, 0, 0, 7, 0, 1);
        do_op(0, 0, 1, 0, 15, 1, 0);
        do_op(15, 15, 0, 0, 0, 0, 0);
        do_op(5, 9, 1, 3, 11, 1, 1);
        do_op(8, 0, 1, 0, 7, 0, 1);

        // Reset in the middle of SHIFT.
        in_valid = 1'b1;
        a        = W'(9);
        b        = W'(4);
        bin      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_d", int'(d), 0);
        chk("midrst_bout", int'(bout), 0);
        chk("midrst_ovf", int'(ovf), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(6, 2, 0, 0, 4, 0, 0);

        for (int i = 0; i < 30; i++) begin
            do_op(int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), -1, -1, -1);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor
